// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared opcode, ALU and FSM constants for the CPU control unit
// Contents:
//   opcode constants and prefixes, ALU op width/default
//   FSM state encodings (ST_STEP only reachable with DEBUG_STEP_EN)
//   ctrl_t: the datapath control bundle and its safe (non-executing) value
package control_unit_pkg;

  // Opcode space: 00_0ooo ALU, 0100_xx LI, 100000 JMP, 100001 JZ, 100010 JNZ, 111111 HALT
  localparam logic [2:0] OP_ALU  = 3'b000;   // opcode[5:3] prefix
  localparam logic [3:0] OP_LI   = 4'b0100;  // opcode[5:2] prefix
  localparam logic [5:0] OP_JMP  = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int         ALU_OP_W = 3;
  localparam logic [2:0] ALU_NONE = 3'b000;

  // Legacy-compatible state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_HALT = 3'd2;
  localparam logic [2:0] ST_SKIP = 3'd3;
  localparam logic [2:0] ST_STEP = 3'd4;

  typedef struct packed {
    logic                s_inc;
    logic                s_inm;
    logic                we3;
    logic                wez;
    logic [ALU_OP_W-1:0] op_alu;
  } ctrl_t;

  // Controls presented whenever no instruction is executing: PC would increment,
  // but nothing is written (pc_we is gated separately).
  localparam ctrl_t CTRL_SAFE = '{
    s_inc:  1'b1,
    s_inm:  1'b0,
    we3:    1'b0,
    wez:    1'b0,
    op_alu: ALU_NONE
  };

endpackage

// File: rtl/control_unit_decoder.sv
// rtl/control_unit_decoder.sv - combinational opcode/zero-flag decoder
// Ports:
//   opcode  in  6  instruction[15:10]
//   z       in  1  registered zero flag
//   ctrl    out    raw datapath controls (ungated by FSM state)
//   legal   out 1  opcode is defined (includes HALT)
//   halt    out 1  opcode is HALT
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       legal,
  output logic       halt
);

  always_comb begin
    ctrl  = CTRL_SAFE;
    legal = 1'b1;
    halt  = 1'b0;
    if (opcode[5:3] == OP_ALU) begin
      ctrl.op_alu = opcode[2:0];
      ctrl.we3    = 1'b1;
      ctrl.wez    = 1'b1;
    end else if (opcode[5:2] == OP_LI) begin
      ctrl.we3   = 1'b1;
      ctrl.s_inm = 1'b1;
    end else begin
      case (opcode)
        OP_JMP:  ctrl.s_inc = 1'b0;
        // Branches use the flag as registered before this edge, so an ALU
        // result written in the same cycle never steers the branch.
        OP_JZ:   ctrl.s_inc = ~z;
        OP_JNZ:  ctrl.s_inc = z;
        OP_HALT: halt = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - run/halt sequencing control unit for the single-cycle CPU
// Optional feature macro: DEBUG_STEP_EN (adds step_req/step_ack and the STEP state)
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   opcode    in   6      instruction[15:10]
//   z         in   1      registered zero flag
//   start     in   1      level; begin/resume execution
//   step_req  in   1      (DEBUG_STEP_EN) request a single instruction from HALT
//   step_ack  out  1      (DEBUG_STEP_EN) one-cycle pulse on HALT entry from STEP
//   s_inc     out  1      1: PC+1, 0: PC<=instruction[9:0]
//   s_inm     out  1      regfile write data = immediate
//   we3       out  1      regfile write enable
//   wez       out  1      zero-flag write enable
//   op_alu    out  3      ALU operation
//   pc_we     out  1      PC write enable
//   halted    out  1      in IDLE or HALT
//   illegal   out  1      sticky: halted on undefined opcode
//   retired   out  RET_W  executed-instruction count (wraps)
module control_unit
  import control_unit_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             start,
`ifdef DEBUG_STEP_EN
  input  logic             step_req,
  output logic             step_ack,
`endif
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [RET_W-1:0] retired
);

  localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

  logic [2:0] state;
  logic [2:0] state_nxt;
  ctrl_t      raw;
  logic       legal;
  logic       halt_op;
  logic       exec;
  logic       do_retire;
  logic       stop;

  control_unit_decoder u_decoder (
    .opcode (opcode),
    .z      (z),
    .ctrl   (raw),
    .legal  (legal),
    .halt   (halt_op)
  );

`ifdef DEBUG_STEP_EN
  logic step_pending;
  assign exec = (state == ST_RUN) || (state == ST_STEP);
`else
  assign exec = (state == ST_RUN);
`endif

  // An executing cycle either retires a legal instruction or stops on HALT/illegal.
  assign do_retire = exec & legal & ~halt_op;
  assign stop      = exec & (~legal | halt_op);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (stop)  state_nxt = ST_HALT;
      ST_HALT: begin
        if (start) state_nxt = ST_SKIP;
`ifdef DEBUG_STEP_EN
        else if (step_req) state_nxt = ST_SKIP;
`endif
      end
`ifdef DEBUG_STEP_EN
      ST_SKIP: state_nxt = step_pending ? ST_STEP : ST_RUN;
      // A step always returns to HALT, whatever the instruction was.
      ST_STEP: state_nxt = ST_HALT;
`else
      ST_SKIP: state_nxt = ST_RUN;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (stop && !legal) begin
        illegal <= 1'b1;
      end else if (state == ST_SKIP) begin
        illegal <= 1'b0;
      end
      if (do_retire) begin
        retired <= retired + RET_ONE;
      end
    end
  end

`ifdef DEBUG_STEP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_pending <= 1'b0;
      step_ack     <= 1'b0;
    end else begin
      step_ack <= (state == ST_STEP);
      // Remember why HALT was left so SKIP knows whether to run or step.
      if (state == ST_HALT) begin
        if (start) begin
          step_pending <= 1'b0;
        end else if (step_req) begin
          step_pending <= 1'b1;
        end
      end
    end
  end
`endif

  // Outputs come straight from state, so an asserted reset forces them safe at once.
  always_comb begin
    s_inc  = CTRL_SAFE.s_inc;
    s_inm  = CTRL_SAFE.s_inm;
    we3    = CTRL_SAFE.we3;
    wez    = CTRL_SAFE.wez;
    op_alu = CTRL_SAFE.op_alu;
    pc_we  = 1'b0;
    if (do_retire) begin
      s_inc  = raw.s_inc;
      s_inm  = raw.s_inm;
      we3    = raw.we3;
      wez    = raw.wez;
      op_alu = raw.op_alu;
      pc_we  = 1'b1;
    end else if (state == ST_SKIP) begin
      // Step the PC past the HALT/illegal word it is parked on.
      pc_we = 1'b1;
    end
  end

  assign halted = (state == ST_IDLE) || (state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit against a behavioural model
`timescale 1ns/1ps
module tb_control_unit;

  localparam int RW = 4;
`ifdef DEBUG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_SKIP = 3, M_STEP = 4;
  localparam int K_ALU = 0, K_LI = 1, K_JMP = 2, K_JZ = 3, K_JNZ = 4, K_HALT = 5, K_ILL = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          z = 1'b0;
  logic          start = 1'b0;
  logic          step_req = 1'b0;
  logic          step_ack;
  logic          s_inc, s_inm, we3, wez, pc_we, halted, illegal;
  logic [2:0]    op_alu;
  logic [RW-1:0] retired;

  always #5 clk = ~clk;

  control_unit #(.RET_W(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .z        (z),
    .start    (start),
`ifdef DEBUG_STEP_EN
    .step_req (step_req),
    .step_ack (step_ack),
`endif
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .we3      (we3),
    .wez      (wez),
    .op_alu   (op_alu),
    .pc_we    (pc_we),
    .halted   (halted),
    .illegal  (illegal),
    .retired  (retired)
  );

`ifndef DEBUG_STEP_EN
  assign step_ack = 1'b0;
`endif

  // {halted, illegal, step_ack, pc_we, s_inc, s_inm, we3, wez, op_alu, retired}
  logic [14:0] act;
  assign act = {halted, illegal, step_ack, pc_we, s_inc, s_inm, we3, wez, op_alu, retired};

  typedef struct {
    logic [14:0] v;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_mode, m_ret;
  bit m_ill, m_ack, m_pend;

  function automatic int kind_of(input logic [5:0] op);
    int n;
    n = int'(op);
    if (n < 8)                return K_ALU;
    if (n >= 16 && n < 20)    return K_LI;
    if (n == 32)              return K_JMP;
    if (n == 33)              return K_JZ;
    if (n == 34)              return K_JNZ;
    if (n == 63)              return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic [14:0] model_out(input logic [5:0] op, input logic zz);
    int   k;
    logic pcw, si, sm, w3, wz, hl;
    logic [2:0] alu;
    logic [RW-1:0] rv;
    k = kind_of(op);
    pcw = 1'b0; si = 1'b1; sm = 1'b0; w3 = 1'b0; wz = 1'b0; alu = 3'd0;
    if ((m_mode == M_RUN || m_mode == M_STEP) && k != K_HALT && k != K_ILL) begin
      pcw = 1'b1;
      case (k)
        K_ALU: begin w3 = 1'b1; wz = 1'b1; alu = op[2:0]; end
        K_LI:  begin w3 = 1'b1; sm = 1'b1; end
        K_JMP: si = 1'b0;
        K_JZ:  si = !zz;
        K_JNZ: si = zz;
        default: ;
      endcase
    end
    if (m_mode == M_SKIP) pcw = 1'b1;
    hl = (m_mode == M_IDLE || m_mode == M_HALT);
    rv = m_ret[RW-1:0];
    return {hl, m_ill, m_ack, pcw, si, sm, w3, wz, alu, rv};
  endfunction

  task automatic model_next(input logic [5:0] op, input logic st, input logic sr);
    int k;
    k = kind_of(op);
    m_ack = 1'b0;
    case (m_mode)
      M_IDLE: if (st) m_mode = M_RUN;
      M_RUN, M_STEP: begin
        if (k == K_ILL) m_ill = 1'b1;
        else if (k != K_HALT) m_ret = (m_ret + 1) % (1 << RW);
        if (m_mode == M_STEP) begin
          m_ack  = 1'b1;
          m_mode = M_HALT;
        end else if (k == K_HALT || k == K_ILL) begin
          m_mode = M_HALT;
        end
      end
      M_HALT: begin
        if (st) begin
          m_mode = M_SKIP; m_pend = 1'b0;
        end else if (STEP_EN && sr) begin
          m_mode = M_SKIP; m_pend = 1'b1;
        end
      end
      M_SKIP: begin
        m_ill  = 1'b0;
        m_mode = m_pend ? M_STEP : M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cycle(input logic [5:0] op, input logic zz, input logic st,
                       input logic sr, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; z = zz; start = st; step_req = sr;
    e.v = model_out(op, zz);
    e.tag = tag;
    sbq.push_back(e);
    model_next(op, st, sr);
  endtask

  // Reset lands mid-cycle with the current opcode still applied, so the check
  // at the following negedge sees the asynchronous effect before any clock edge.
  task automatic do_reset(input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    reset = 1'b0; start = 1'b0; step_req = 1'b0;
    m_mode = M_IDLE; m_ret = 0; m_ill = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
    e.v = model_out(opcode, z);
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.tag, act, e.v);
      end
    end
  end

  task automatic rand_op(output logic [5:0] op);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: op = {3'b000, 3'($urandom_range(0, 7))};
      4:          op = {4'b0100, 2'($urandom_range(0, 3))};
      5:          op = 6'b100000;
      6:          op = 6'b100001;
      7:          op = 6'b100010;
      8:          op = 6'b111111;
      default:    op = 6'($urandom_range(0, 63));
    endcase
  endtask

  initial begin
    logic [5:0] rop;
    do_reset("reset_state");
    cycle(6'd0, 1'b0, 1'b0, 1'b0, "idle_no_start");
    cycle(6'd0, 1'b0, 1'b1, 1'b0, "idle_start");
    // program: ADD, LI, JMP 0x003, HALT
    cycle(6'b000000, 1'b0, 1'b0, 1'b0, "prog_add");
    cycle(6'b010000, 1'b0, 1'b0, 1'b0, "prog_li");
    cycle(6'b100000, 1'b0, 1'b0, 1'b0, "prog_jmp");
    cycle(6'b111111, 1'b0, 1'b1, 1'b0, "prog_halt");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "prog_halted");
    // resume and exercise branches
    cycle(6'b111111, 1'b0, 1'b1, 1'b0, "halt_start");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "skip_halt");
    cycle(6'b100001, 1'b1, 1'b0, 1'b0, "jz_taken");
    cycle(6'b100001, 1'b0, 1'b0, 1'b0, "jz_not_taken");
    cycle(6'b100010, 1'b1, 1'b0, 1'b0, "jnz_not_taken");
    cycle(6'b100010, 1'b0, 1'b0, 1'b0, "jnz_taken");
    cycle(6'b000011, 1'b0, 1'b0, 1'b0, "alu_sets_wez");
    cycle(6'b100001, 1'b0, 1'b0, 1'b0, "jz_after_alu");
    // illegal opcode trap and recovery
    cycle(6'b110000, 1'b0, 1'b0, 1'b0, "illegal_exec");
    cycle(6'b110000, 1'b0, 1'b0, 1'b0, "illegal_halted");
    cycle(6'b110000, 1'b0, 1'b1, 1'b0, "illegal_start");
    cycle(6'b110000, 1'b0, 1'b0, 1'b0, "illegal_skip");
    cycle(6'b000001, 1'b0, 1'b0, 1'b0, "illegal_cleared");
    // reset while running
    do_reset("reset_mid_run");
    // retired wrap with 4-bit counter
    cycle(6'd0, 1'b0, 1'b1, 1'b0, "wrap_start");
    for (int i = 0; i < 17; i++) cycle(6'(i % 8), 1'b0, 1'b0, 1'b0, "wrap_alu");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "wrap_halt");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "wrap_done");
`ifdef DEBUG_STEP_EN
    cycle(6'b111111, 1'b0, 1'b0, 1'b1, "step_req");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "step_skip");
    cycle(6'b000010, 1'b0, 1'b0, 1'b0, "step_exec");
    cycle(6'b000010, 1'b0, 1'b0, 1'b0, "step_ack_pulse");
    cycle(6'b000010, 1'b0, 1'b1, 1'b1, "step_start_prio");
    cycle(6'b111111, 1'b0, 1'b0, 1'b0, "step_prio_skip");
    cycle(6'b000100, 1'b0, 1'b0, 1'b0, "step_prio_run");
    cycle(6'b000100, 1'b0, 1'b0, 1'b0, "step_prio_run2");
`endif
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_op(rop);
      cycle(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), "random");
      if (i == 300) do_reset("reset_random");
    end
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
